// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG scan master: TAP state codes, command opcodes,
// master sequencer states and default sizing.
package jtag_pkg;

   localparam int JTAG_MAX_LEN = 32;
   localparam int JTAG_LEN_W   = 6;
   localparam int INIT_ONES    = 5;

   // Classic 1149.1 state encoding, shared with tap_ctl so shadow and target can be compared.
   typedef enum logic [3:0] {
      TAP_EXIT2_DR = 4'h0, TAP_EXIT1_DR = 4'h1, TAP_SHIFT_DR = 4'h2, TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR   = 4'h6, TAP_SEL_DR   = 4'h7,
      TAP_EXIT2_IR = 4'h8, TAP_EXIT1_IR = 4'h9, TAP_SHIFT_IR = 4'hA, TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR   = 4'hE, TAP_TLR      = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {
      OP_TAP_RESET = 2'b00,
      OP_IR_SCAN   = 2'b01,
      OP_DR_SCAN   = 2'b10,
      OP_RUNTEST   = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      M_INIT, M_IDLE, M_NAV_IN, M_SHIFT, M_NAV_OUT, M_RUN, M_RESP
   } mst_state_e;

endpackage

// File: rtl/jtag_scan_master_tap_shadow.sv
// Shadow copy of the target TAP controller: advances on every TCK edge with the
// TMS value the target consumes on that edge.
module tap_shadow
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output tap_state_e state
);

   tap_state_e state_d, state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= TAP_TLR;
      else     state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: turns reset/IR/DR/RUNTEST commands into registered
// TMS/TDI streams, captures TDO and always leaves the target in Run-Test/Idle.
module jtag_scan_master
   import jtag_pkg::*;
#(
   parameter int MAX_LEN = JTAG_MAX_LEN,
   parameter int LEN_W   = JTAG_LEN_W
) (
   input  logic               TCK,
   input  logic               TRST,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [1:0]         CMD_OP,
   input  logic [LEN_W-1:0]   CMD_LEN,
   input  logic [MAX_LEN-1:0] CMD_DATA,
   output logic               TMS_OUT,
   output logic               TDI_OUT,
   input  logic               TDO_IN,
   output logic               RSP_VALID,
   output logic [MAX_LEN-1:0] RSP_DATA,
   output logic               RSP_ERR,
   output logic               BUSY
);

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   mst_state_e         st_d, st_q;
   cmd_op_e            op_d, op_q;
   logic [LEN_W-1:0]   cnt_d, cnt_q, len_d, len_q, pre_last;
   logic [MAX_LEN-1:0] dat_d, dat_q, rx_d, rx_q, rdat_d, rdat_q;
   logic               tms_d, tms_q, tdi_d, tdi_q, rdy_d, rdy_q, busy_d, busy_q;
   logic               rvld_d, rvld_q, rerr_d, rerr_q, rcmd_d, rcmd_q;
   logic               accept, bad_len;
   tap_state_e         tap_st;

   tap_shadow u_shadow (.clk(TCK), .rst(TRST), .tms(tms_q), .state(tap_st));

   assign CMD_READY = rdy_q && (tap_st == TAP_RTI);
   assign accept    = CMD_VALID && CMD_READY;
   assign bad_len   = (CMD_LEN == '0) || (CMD_LEN > MAX_L);
   // Last preamble index: IR walks 1,1,0,0 and DR walks 1,0,0 into Shift.
   assign pre_last  = (op_q == OP_IR_SCAN) ? LEN_W'(3) : LEN_W'(2);

   always_comb begin
      st_d = st_q;   op_d = op_q;     cnt_d = cnt_q;   len_d = len_q;
      dat_d = dat_q; rx_d = rx_q;     tms_d = tms_q;   tdi_d = tdi_q;
      rdy_d = rdy_q; busy_d = busy_q; rvld_d = 1'b0;   rdat_d = rdat_q;
      rerr_d = rerr_q; rcmd_d = rcmd_q;
      case (st_q)
         M_INIT: begin
            if (cnt_q == LEN_W'(INIT_ONES)) begin
               tms_d  = 1'b0;
               rdy_d  = 1'b1;
               rcmd_d = 1'b0;
               if (rcmd_q) begin
                  st_d = M_RESP; rvld_d = 1'b1; rerr_d = 1'b0; rdat_d = '0;
               end else begin
                  st_d = M_IDLE;
               end
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
               tms_d = (cnt_q < LEN_W'(INIT_ONES - 1));
            end
         end
         M_IDLE, M_RESP: begin
            st_d = M_IDLE; busy_d = 1'b0; tms_d = 1'b0; tdi_d = 1'b0;
            if (accept) begin
               op_d = cmd_op_e'(CMD_OP); len_d = CMD_LEN; dat_d = CMD_DATA;
               rx_d = '0; cnt_d = '0; busy_d = 1'b1; rdy_d = 1'b0;
               case (cmd_op_e'(CMD_OP))
                  OP_TAP_RESET: begin st_d = M_INIT; rcmd_d = 1'b1; tms_d = 1'b1; end
                  OP_RUNTEST: begin
                     if (CMD_LEN == '0) begin
                        st_d = M_RESP; rvld_d = 1'b1; rdy_d = 1'b1; rerr_d = 1'b0; rdat_d = '0;
                     end else begin
                        st_d = M_RUN;
                     end
                  end
                  default: begin
                     if (bad_len) begin
                        st_d = M_RESP; rvld_d = 1'b1; rdy_d = 1'b1; rerr_d = 1'b1; rdat_d = '0;
                     end else begin
                        st_d = M_NAV_IN; tms_d = 1'b1;
                     end
                  end
               endcase
            end
         end
         M_NAV_IN: begin
            if (cnt_q == pre_last) begin
               st_d = M_SHIFT; cnt_d = '0;
               tdi_d = dat_q[0]; dat_d = dat_q >> 1;
               tms_d = (len_q == LEN_W'(1));
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
               tms_d = (op_q == OP_IR_SCAN) && (cnt_q == '0);
            end
         end
         M_SHIFT: begin
            // TDO enters at the top; the final right-align happens on completion.
            rx_d = {TDO_IN, rx_q[MAX_LEN-1:1]};
            if (cnt_q == len_q - LEN_W'(1)) begin
               st_d = M_NAV_OUT; cnt_d = '0; tms_d = 1'b1; tdi_d = 1'b0;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
               tdi_d = dat_q[0]; dat_d = dat_q >> 1;
               tms_d = (cnt_q + LEN_W'(2) == len_q);
            end
         end
         M_NAV_OUT: begin
            if (cnt_q == '0) begin
               cnt_d = LEN_W'(1); tms_d = 1'b0;
            end else begin
               st_d = M_RESP; rvld_d = 1'b1; rdy_d = 1'b1; rerr_d = 1'b0;
               rdat_d = rx_q >> (MAX_L - len_q);
            end
         end
         M_RUN: begin
            if (cnt_q == len_q - LEN_W'(1)) begin
               st_d = M_RESP; rvld_d = 1'b1; rdy_d = 1'b1; rerr_d = 1'b0; rdat_d = '0;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         default: st_d = M_INIT;
      endcase
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         st_q <= M_INIT;  op_q <= OP_TAP_RESET; cnt_q <= '0;   len_q <= '0;
         dat_q <= '0;     rx_q <= '0;           tms_q <= 1'b1; tdi_q <= 1'b0;
         rdy_q <= 1'b0;   busy_q <= 1'b0;       rvld_q <= 1'b0; rdat_q <= '0;
         rerr_q <= 1'b0;  rcmd_q <= 1'b0;
      end else begin
         st_q <= st_d;    op_q <= op_d;         cnt_q <= cnt_d; len_q <= len_d;
         dat_q <= dat_d;  rx_q <= rx_d;         tms_q <= tms_d; tdi_q <= tdi_d;
         rdy_q <= rdy_d;  busy_q <= busy_d;     rvld_q <= rvld_d; rdat_q <= rdat_d;
         rerr_q <= rerr_d; rcmd_q <= rcmd_d;
      end
   end

   assign TMS_OUT   = tms_q;
   assign TDI_OUT   = tdi_q;
   assign RSP_VALID = rvld_q;
   assign RSP_DATA  = rdat_q;
   assign RSP_ERR   = rerr_q;
   assign BUSY      = busy_q;

endmodule
